cache_ram_sequencer: RTL and testbench
======================================

# cache_ram_sequencer

Write-port controller for one cache way's data RAM and tag RAM. Sequences the post-reset tag invalidation sweep, line refills from the memory bus (tag invalidate, data beats, tag commit) and single-set invalidations. It also arbitrates the shared data-RAM write port between refill beats and CPU store hits. Sits between the cache FSM and the `data_ram`/`tag_ram` instances; it drives only their write ports.

## Interface
- `INDEX_WIDTH`, 7, set index bits; tag RAM depth is 2^INDEX_WIDTH.
- `OFFSET_WIDTH`, 3, word-offset bits; a line is 2^OFFSET_WIDTH 32-bit words; data RAM address is {index, offset}.
- `TAG_WIDTH`, 20, tag bits; the tag RAM word is {valid, tag}, TAG_WIDTH+1 bits.

Ports:
- `i_clk` in 1: the single clock.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_refill_req` in 1, `i_refill_index` in INDEX_WIDTH, `i_refill_tag` in TAG_WIDTH, `i_refill_offset` in OFFSET_WIDTH: refill request; the request is held until `o_refill_ack`.
- `o_refill_ack` out 1: refill accepted this cycle.
- `o_refill_done` out 1: one-cycle pulse when the tag is committed.
- `i_bus_valid` in 1, `i_bus_data` in 32: refill data beat.
- `o_bus_ready` out 1: beat accepted when both `i_bus_valid` and `o_bus_ready` are high.
- `i_inv_req` in 1, `i_inv_index` in INDEX_WIDTH: request to invalidate one set.
- `o_inv_ack` out 1: invalidation written this cycle.
- `i_store_req` in 1, `i_store_addr` in INDEX_WIDTH+OFFSET_WIDTH, `i_store_data` in 32, `i_store_byteen` in 4: store-hit write.
- `o_store_ready` out 1: store written this cycle.
- `o_init_busy` out 1: invalidation sweep in progress.
- `o_dram_wen` out 1, `o_dram_wbyteen` out 4, `o_dram_waddr` out INDEX_WIDTH+OFFSET_WIDTH, `o_dram_wdata` out 32: data RAM write port.
- `o_tram_wen` out 1, `o_tram_waddr` out INDEX_WIDTH, `o_tram_wtag` out TAG_WIDTH+1: tag RAM write port; bit TAG_WIDTH is the valid bit.

## Operation
- States: INIT, IDLE, REFILL, COMMIT.
  - Registered: state, counter (INDEX_WIDTH bits), refill index, refill tag, beat counter (OFFSET_WIDTH bits) and beats-remaining count.
- **INIT:** for each cycle `n` from 0 to 2^INDEX_WIDTH−1, write tag `'0` to index `n`. After index 2^INDEX_WIDTH−1, go to IDLE.
  - `o_init_busy` is 1 throughout INIT.
  - No acks or readies are asserted in INIT.
- **IDLE, tag-port priority:** refill first, then invalidate.
- **Refill accept (IDLE):**
  - `o_refill_ack` is asserted.
  - Tag {0, tag} is written at the refill index, invalidating any stale line.
  - Index and tag are latched; the beat counter is loaded with the start offset; the next state is REFILL.
- **Invalidate accept (IDLE, no refill request):** `o_inv_ack` is asserted and {0, '0} is written at `i_inv_index`.
- **REFILL:**
  - `o_bus_ready` is 1.
  - Each accepted beat writes `i_bus_data` to {refill index, beat counter} with byteen `4'hF`.
  - The beat counter increments modulo 2^OFFSET_WIDTH.
  - After 2^OFFSET_WIDTH beats, go to COMMIT.
- **COMMIT:** write {1, refill tag} at the refill index, pulse `o_refill_done`, go to IDLE. COMMIT lasts exactly one cycle.
- **Store arbitration:** `o_store_ready` = !INIT && !(bus beat this cycle) && !((REFILL or COMMIT) && store index == refill index).
  - When ready, the store drives the data port with its own byteen, address and data.
  - Refill beats always win the data port.
  - Stores proceed in parallel with tag-port activity.
- Each write-port output is a combinational mux of the selected source. Enables are 0 when no source is selected.

## Timing
- While `i_rst_n` is low, all outputs are 0 except `o_init_busy`, which is 1.
- The state resets to INIT with the counter at 0; the first sweep write occurs in the first clock edge's cycle after reset deasserts.
- Every write is issued in the same cycle as its handshake, with zero added latency. RAM forwarding handles read-after-write.
- Minimum refill takes 2 + 2^OFFSET_WIDTH cycles: ack cycle, beats, commit. Bus gaps extend REFILL without limit.
- A refill request arriving in COMMIT waits until IDLE; back-to-back refills are spaced by at least one IDLE cycle.
- If reset asserts mid-refill, the refill is aborted with no `o_refill_done`. The set stays invalid after the new sweep, and the requester reissues.
- A store and a refill ack in the same IDLE cycle are both performed.

## Configuration
- `CACHE_SEQ_CRITICAL_WORD_EN` defined:
  - The beat counter starts at `i_refill_offset` and wraps.
  - The requested word is written in the first beat.
- Undefined:
  - The beat counter always starts at 0.
  - `i_refill_offset` is ignored.
- In both cases the refill completes after exactly 2^OFFSET_WIDTH beats.

## Structure
- Package `cache_seq_pkg` holds:
  - the state enum `cache_seq_state_e`;
  - the tag-entry typedef `tag_entry_t` (valid, tag);
  - the constant `LINE_WORDS`.
- Sub-module `cache_seq_wrap_cnt` is a loadable counter with wrap and terminal-count flag. It is instanced for the sweep index and for the beat counter.

## Test plan
- Reset release with INDEX_WIDTH=7: exactly 128 tag writes (indices 0..127, data `'0`) → `o_init_busy` falls in the 129th cycle after reset.
- Refill at index 5, tag 0xABCDE, 8 gap-free beats D0..D7: tag 5 is written invalid in the ack cycle, then data addresses 40..47 receive D0..D7, then {1, 0xABCDE} is written and `o_refill_done` pulses for 1 cycle.
- With the macro enabled, offset 6: beats land at addresses 46, 47, 40..45 in that order.
- During that refill, a store to address 0x102 (index 32) while bus_valid is low → `o_store_ready`=1, byteen passed through. A store to address 41 → stalled until IDLE.
- Simultaneous refill and invalidate requests in IDLE → refill acked, `o_inv_ack`=0, invalidate acked in the next IDLE cycle.
- Reset pulse after beat 3 of a refill → no `o_refill_done`, INIT sweep restarts from index 0.

Source files
------------

// File: rtl/cache_seq_pkg.sv
// Shared types and constants for the cache way RAM write sequencer.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package cache_seq_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_REFILL = 2'd2,
        ST_COMMIT = 2'd3
    } cache_seq_state_e;

    // Default geometry of one cache way.
    localparam int CSEQ_INDEX_WIDTH  = 7;
    localparam int CSEQ_OFFSET_WIDTH = 3;
    localparam int CSEQ_TAG_WIDTH    = 20;

    // Tag RAM word: valid bit on top of the tag.
    typedef struct packed {
        logic                      valid;
        logic [CSEQ_TAG_WIDTH-1:0] tag;
    } tag_entry_t;

    localparam int LINE_WORDS = 1 << CSEQ_OFFSET_WIDTH;

    // Words per line for an arbitrary offset width.
    function automatic int line_words(input int offset_width);
        return 1 << offset_width;
    endfunction

endpackage

// File: rtl/cache_seq_wrap_cnt.sv
// Loadable up-counter that wraps at 2^WIDTH, with an all-ones terminal-count flag.
// Latency: load/increment visible one cycle after the enabling edge.
// Backpressure: none; counts whenever i_inc is high.
module cache_seq_wrap_cnt #(
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_cnt;

    // Load has priority over increment; increment wraps naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = &r_cnt;

endmodule

// File: rtl/cache_ram_sequencer.sv
// Write-port sequencer for one cache way: init sweep, line refill, set invalidate, store arbitration.
// Latency: every RAM write is issued combinationally in the cycle of its handshake.
// Backpressure: refill beats stall via o_bus_ready; stores stall via o_store_ready. Optional: CACHE_SEQ_CRITICAL_WORD_EN.
module cache_ram_sequencer
    import cache_seq_pkg::*;
#(
    parameter int INDEX_WIDTH  = CSEQ_INDEX_WIDTH,
    parameter int OFFSET_WIDTH = CSEQ_OFFSET_WIDTH,
    parameter int TAG_WIDTH    = CSEQ_TAG_WIDTH
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_refill_req,
    input  logic [INDEX_WIDTH-1:0]          i_refill_index,
    input  logic [TAG_WIDTH-1:0]            i_refill_tag,
    input  logic [OFFSET_WIDTH-1:0]         i_refill_offset,
    output logic                            o_refill_ack,
    output logic                            o_refill_done,
    input  logic                            i_bus_valid,
    input  logic [31:0]                     i_bus_data,
    output logic                            o_bus_ready,
    input  logic                            i_inv_req,
    input  logic [INDEX_WIDTH-1:0]          i_inv_index,
    output logic                            o_inv_ack,
    input  logic                            i_store_req,
    input  logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] i_store_addr,
    input  logic [31:0]                     i_store_data,
    input  logic [3:0]                      i_store_byteen,
    output logic                            o_store_ready,
    output logic                            o_init_busy,
    output logic                            o_dram_wen,
    output logic [3:0]                      o_dram_wbyteen,
    output logic [INDEX_WIDTH+OFFSET_WIDTH-1:0] o_dram_waddr,
    output logic [31:0]                     o_dram_wdata,
    output logic                            o_tram_wen,
    output logic [INDEX_WIDTH-1:0]          o_tram_waddr,
    output logic [TAG_WIDTH:0]              o_tram_wtag
);

    localparam logic [OFFSET_WIDTH:0] LINE_CNT = (OFFSET_WIDTH+1)'(line_words(OFFSET_WIDTH));

    cache_seq_state_e          r_state;
    logic [INDEX_WIDTH-1:0]    r_index;
    logic [TAG_WIDTH-1:0]      r_tag;
    logic [OFFSET_WIDTH:0]     r_beats_left;

    logic [INDEX_WIDTH-1:0]    w_sweep_idx;
    logic                      w_sweep_tc;
    logic [OFFSET_WIDTH-1:0]   w_beat_off;
    logic                      w_unused_beat_tc;
    logic [OFFSET_WIDTH-1:0]   w_start_off;
    logic                      w_in_init;
    logic                      w_in_idle;
    logic                      w_in_refill;
    logic                      w_in_commit;
    logic                      w_refill_acc;
    logic                      w_inv_acc;
    logic                      w_beat;
    logic                      w_store_conflict;
    logic                      w_store_ready;
    logic                      w_store_wr;

`ifdef CACHE_SEQ_CRITICAL_WORD_EN
    assign w_start_off = i_refill_offset;
`else
    logic w_unused_offset;
    assign w_unused_offset = ^i_refill_offset;
    assign w_start_off     = '0;
`endif

    assign w_in_init    = (r_state == ST_INIT);
    assign w_in_idle    = (r_state == ST_IDLE);
    assign w_in_refill  = (r_state == ST_REFILL);
    assign w_in_commit  = (r_state == ST_COMMIT);
    assign w_refill_acc = w_in_idle && i_refill_req;
    assign w_inv_acc    = w_in_idle && !i_refill_req && i_inv_req;
    assign w_beat       = w_in_refill && i_bus_valid;

    // A store into the line being refilled must wait until the tag is committed.
    assign w_store_conflict = (w_in_refill || w_in_commit) &&
                              (i_store_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH] == r_index);
    assign w_store_ready    = !w_in_init && !w_beat && !w_store_conflict;
    assign w_store_wr       = w_store_ready && i_store_req;

    cache_seq_wrap_cnt #(.WIDTH(INDEX_WIDTH)) u_sweep_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (w_in_init),
        .o_cnt      (w_sweep_idx),
        .o_tc       (w_sweep_tc)
    );

    cache_seq_wrap_cnt #(.WIDTH(OFFSET_WIDTH)) u_beat_cnt (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_refill_acc),
        .i_load_val (w_start_off),
        .i_inc      (w_beat),
        .o_cnt      (w_beat_off),
        .o_tc       (w_unused_beat_tc)
    );

    // Sequencer state: sweep, wait, collect beats, commit tag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
        end else begin
            unique case (r_state)
                ST_INIT:   if (w_sweep_tc) r_state <= ST_IDLE;
                ST_IDLE:   if (w_refill_acc) r_state <= ST_REFILL;
                ST_REFILL: if (w_beat && (r_beats_left == (OFFSET_WIDTH+1)'(1))) r_state <= ST_COMMIT;
                ST_COMMIT: r_state <= ST_IDLE;
                default:   r_state <= ST_INIT;
            endcase
        end
    end

    // Refill context captured at accept; beat count tracked independently of start offset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_index      <= '0;
            r_tag        <= '0;
            r_beats_left <= '0;
        end else if (w_refill_acc) begin
            r_index      <= i_refill_index;
            r_tag        <= i_refill_tag;
            r_beats_left <= LINE_CNT;
        end else if (w_beat) begin
            r_beats_left <= r_beats_left - 1'b1;
        end
    end

    // Tag-port mux: sweep, refill invalidate, set invalidate, commit.
    always_comb begin
        o_tram_wen    = 1'b0;
        o_tram_waddr  = '0;
        o_tram_wtag   = '0;
        o_refill_ack  = 1'b0;
        o_inv_ack     = 1'b0;
        o_refill_done = 1'b0;
        if (w_in_init) begin
            // Held off while reset is asserted so the port is quiet in reset.
            o_tram_wen   = i_rst_n;
            o_tram_waddr = w_sweep_idx;
        end else if (w_refill_acc) begin
            o_refill_ack = 1'b1;
            o_tram_wen   = 1'b1;
            o_tram_waddr = i_refill_index;
            o_tram_wtag  = {1'b0, i_refill_tag};
        end else if (w_inv_acc) begin
            o_inv_ack    = 1'b1;
            o_tram_wen   = 1'b1;
            o_tram_waddr = i_inv_index;
        end else if (w_in_commit) begin
            o_refill_done = 1'b1;
            o_tram_wen    = 1'b1;
            o_tram_waddr  = r_index;
            o_tram_wtag   = {1'b1, r_tag};
        end
    end

    // Data-port mux: refill beats always win over stores.
    always_comb begin
        o_dram_wen     = 1'b0;
        o_dram_wbyteen = '0;
        o_dram_waddr   = '0;
        o_dram_wdata   = '0;
        if (w_beat) begin
            o_dram_wen     = 1'b1;
            o_dram_wbyteen = 4'hF;
            o_dram_waddr   = {r_index, w_beat_off};
            o_dram_wdata   = i_bus_data;
        end else if (w_store_wr) begin
            o_dram_wen     = 1'b1;
            o_dram_wbyteen = i_store_byteen;
            o_dram_waddr   = i_store_addr;
            o_dram_wdata   = i_store_data;
        end
    end

    assign o_bus_ready   = w_in_refill;
    assign o_store_ready = w_store_ready;
    assign o_init_busy   = w_in_init;

endmodule

// File: tb/tb_cache_ram_sequencer.sv
// Randomized scoreboard bench for cache_ram_sequencer.
// Latency: expected RAM writes are queued at issue and popped when the DUT writes.
// Backpressure: handshakes are sampled on the falling edge, inputs driven 1 time unit after rising.
module tb_cache_ram_sequencer;
    import cache_seq_pkg::*;

    localparam int IW = 7;
    localparam int OW = 3;
    localparam int TW = 20;
    localparam int AW = IW + OW;
    localparam int LW = LINE_WORDS;
    localparam int SETS = 1 << IW;

    typedef logic [IW+TW:0]  texp_t;
    typedef logic [AW+35:0]  dexp_t;

    logic            clk = 1'b0;
    logic            i_rst_n = 1'b1;
    logic            i_refill_req = 1'b0;
    logic [IW-1:0]   i_refill_index = '0;
    logic [TW-1:0]   i_refill_tag = '0;
    logic [OW-1:0]   i_refill_offset = '0;
    logic            o_refill_ack, o_refill_done;
    logic            i_bus_valid = 1'b0;
    logic [31:0]     i_bus_data = '0;
    logic            o_bus_ready;
    logic            i_inv_req = 1'b0;
    logic [IW-1:0]   i_inv_index = '0;
    logic            o_inv_ack;
    logic            i_store_req = 1'b0;
    logic [AW-1:0]   i_store_addr = '0;
    logic [31:0]     i_store_data = '0;
    logic [3:0]      i_store_byteen = '0;
    logic            o_store_ready, o_init_busy;
    logic            o_dram_wen;
    logic [3:0]      o_dram_wbyteen;
    logic [AW-1:0]   o_dram_waddr;
    logic [31:0]     o_dram_wdata;
    logic            o_tram_wen;
    logic [IW-1:0]   o_tram_waddr;
    logic [TW:0]     o_tram_wtag;

    int n_cmp = 0;
    int n_err = 0;
    int exp_done = 0;
    int got_done = 0;
    texp_t tq[$];
    dexp_t dq[$];
    texp_t t_exp;
    dexp_t d_exp;

    always #5 clk = ~clk;

    cache_ram_sequencer #(.INDEX_WIDTH(IW), .OFFSET_WIDTH(OW), .TAG_WIDTH(TW)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_refill_req(i_refill_req), .i_refill_index(i_refill_index),
        .i_refill_tag(i_refill_tag), .i_refill_offset(i_refill_offset),
        .o_refill_ack(o_refill_ack), .o_refill_done(o_refill_done),
        .i_bus_valid(i_bus_valid), .i_bus_data(i_bus_data), .o_bus_ready(o_bus_ready),
        .i_inv_req(i_inv_req), .i_inv_index(i_inv_index), .o_inv_ack(o_inv_ack),
        .i_store_req(i_store_req), .i_store_addr(i_store_addr), .i_store_data(i_store_data),
        .i_store_byteen(i_store_byteen), .o_store_ready(o_store_ready), .o_init_busy(o_init_busy),
        .o_dram_wen(o_dram_wen), .o_dram_wbyteen(o_dram_wbyteen), .o_dram_waddr(o_dram_waddr),
        .o_dram_wdata(o_dram_wdata), .o_tram_wen(o_tram_wen), .o_tram_waddr(o_tram_waddr),
        .o_tram_wtag(o_tram_wtag)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // Monitor: every RAM write must match the head of its expectation queue.
    always @(negedge clk) begin
        if (o_tram_wen) begin
            n_cmp++;
            if (tq.size() == 0) begin
                n_err++;
                $display("FAIL tag_write: got addr=%0d tag=%h, required no write", o_tram_waddr, o_tram_wtag);
            end else begin
                t_exp = tq.pop_front();
                if ({o_tram_waddr, o_tram_wtag} !== t_exp) begin
                    n_err++;
                    $display("FAIL tag_write: got addr=%0d tag=%h, required addr=%0d tag=%h",
                             o_tram_waddr, o_tram_wtag, t_exp[IW+TW:TW+1], t_exp[TW:0]);
                end
            end
        end
        if (o_dram_wen) begin
            n_cmp++;
            if (dq.size() == 0) begin
                n_err++;
                $display("FAIL data_write: got addr=%0d be=%h data=%h, required no write",
                         o_dram_waddr, o_dram_wbyteen, o_dram_wdata);
            end else begin
                d_exp = dq.pop_front();
                if ({o_dram_waddr, o_dram_wbyteen, o_dram_wdata} !== d_exp) begin
                    n_err++;
                    $display("FAIL data_write: got addr=%0d be=%h data=%h, required addr=%0d be=%h data=%h",
                             o_dram_waddr, o_dram_wbyteen, o_dram_wdata,
                             d_exp[AW+35:36], d_exp[35:32], d_exp[31:0]);
                end
            end
        end
        if (o_refill_done) got_done++;
    end

    function automatic texp_t tag_w(input logic [IW-1:0] idx, input logic v, input logic [TW-1:0] tg);
        tag_entry_t e;
        e.valid = v;
        e.tag   = tg;
        return {idx, e};
    endfunction

    task automatic quiet_inputs();
        i_refill_req = 1'b0; i_bus_valid = 1'b0; i_inv_req = 1'b0; i_store_req = 1'b0;
    endtask

    // Reset, check quiet outputs, then expect a full sweep of invalid tags.
    task automatic do_reset();
        int cnt;
        quiet_inputs();
        i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs_zero", 64'(|{o_refill_ack, o_refill_done, o_bus_ready, o_inv_ack, o_store_ready,
             o_dram_wen, o_dram_wbyteen, o_dram_waddr, o_dram_wdata, o_tram_wen, o_tram_waddr, o_tram_wtag}), 0);
        chk("reset_init_busy", 64'(o_init_busy), 1);
        for (int i = 0; i < SETS; i++) tq.push_back(tag_w(IW'(i), 1'b0, '0));
        @(posedge clk); #1;
        i_rst_n = 1'b1;
        cnt = 0;
        while (o_init_busy && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("init_sweep_edges", 64'(cnt), 64'(SETS));
        chk("init_sweep_drained", 64'(tq.size()), 0);
    endtask

    task automatic do_store(input logic [AW-1:0] a);
        @(posedge clk); #1;
        i_store_req = 1'b1; i_store_addr = a; i_store_data = $urandom; i_store_byteen = 4'($urandom);
        dq.push_back({a, i_store_byteen, i_store_data});
        @(negedge clk);
        chk("store_ready_idle", 64'(o_store_ready), 1);
        @(posedge clk); #1;
        i_store_req = 1'b0;
    endtask

    task automatic do_inv(input logic [IW-1:0] idx);
        @(posedge clk); #1;
        i_inv_req = 1'b1; i_inv_index = idx;
        tq.push_back(tag_w(idx, 1'b0, '0));
        @(negedge clk);
        chk("inv_ack", 64'(o_inv_ack), 1);
        @(posedge clk); #1;
        i_inv_req = 1'b0;
    endtask

    // Full refill transaction; abort_after >= 0 asserts reset after that many beats.
    task automatic do_refill(input logic [IW-1:0] idx, input logic [TW-1:0] tg, input logic [OW-1:0] off,
                             input int gap_pct, input bit store_with_ack, input bit with_inv,
                             input logic [IW-1:0] inv_idx, input bit commit_conflict, input int abort_after);
        logic [OW-1:0] start;
        logic [AW-1:0] sa;
        int b, cyc, sk, done_before;
        bit v;
        @(posedge clk); #1;
        i_refill_req = 1'b1; i_refill_index = idx; i_refill_tag = tg; i_refill_offset = off;
        tq.push_back(tag_w(idx, 1'b0, tg));
        if (with_inv) begin i_inv_req = 1'b1; i_inv_index = inv_idx; end
        if (store_with_ack) begin
            i_store_req = 1'b1; i_store_addr = AW'($urandom); i_store_data = $urandom; i_store_byteen = 4'($urandom);
            dq.push_back({i_store_addr, i_store_byteen, i_store_data});
        end
        @(negedge clk);
        chk("refill_ack", 64'(o_refill_ack), 1);
        if (with_inv) chk("inv_ack_loses_to_refill", 64'(o_inv_ack), 0);
        if (store_with_ack) chk("store_with_refill_ack", 64'(o_store_ready), 1);
        @(posedge clk); #1;
        i_refill_req = 1'b0; i_store_req = 1'b0;
`ifdef CACHE_SEQ_CRITICAL_WORD_EN
        start = off;
`else
        start = '0;
`endif
        b = 0; cyc = 0;
        while (b < LW && cyc < 400) begin
            v = ($urandom_range(99) >= 32'(gap_pct));
            sk = $urandom_range(3);
            i_bus_valid = v;
            i_store_req = 1'b0;
            if (v) begin
                i_bus_data = $urandom;
                dq.push_back({idx, OW'(int'(start) + b), 4'hF, i_bus_data});
            end
            if (sk == 1 || sk == 2) begin
                if (sk == 1) sa = {IW'(int'(idx) + 1 + $urandom_range(SETS - 2)), OW'($urandom)};
                else         sa = {idx, OW'($urandom)};
                i_store_req = 1'b1; i_store_addr = sa; i_store_data = $urandom; i_store_byteen = 4'($urandom);
                if (!v && sk == 1) dq.push_back({sa, i_store_byteen, i_store_data});
            end
            @(negedge clk);
            chk("bus_ready_in_refill", 64'(o_bus_ready), 1);
            if (sk == 1 || sk == 2) chk("store_ready_in_refill", 64'(o_store_ready), 64'(!v && sk == 1));
            if (with_inv) chk("inv_held_in_refill", 64'(o_inv_ack), 0);
            @(posedge clk); #1;
            if (v) b++;
            cyc++;
            if (abort_after >= 0 && b == abort_after) begin
                done_before = got_done;
                do_reset();
                chk("abort_no_done", 64'(got_done), 64'(done_before));
                return;
            end
        end
        chk("refill_beats_complete", 64'(b), 64'(LW));
        i_bus_valid = 1'b0; i_store_req = 1'b0;
        tq.push_back(tag_w(idx, 1'b1, tg));
        exp_done++;
        if (commit_conflict) begin
            i_store_req = 1'b1; i_store_addr = {idx, OW'($urandom)};
            i_store_data = $urandom; i_store_byteen = 4'($urandom);
        end
        @(negedge clk);
        chk("refill_done_pulse", 64'(o_refill_done), 1);
        chk("bus_ready_off_in_commit", 64'(o_bus_ready), 0);
        if (commit_conflict) chk("store_stall_in_commit", 64'(o_store_ready), 0);
        if (with_inv) chk("inv_held_in_commit", 64'(o_inv_ack), 0);
        @(posedge clk); #1;
        if (commit_conflict) dq.push_back({i_store_addr, i_store_byteen, i_store_data});
        if (with_inv) tq.push_back(tag_w(inv_idx, 1'b0, '0));
        @(negedge clk);
        chk("refill_done_one_cycle", 64'(o_refill_done), 0);
        if (commit_conflict) chk("store_ready_after_commit", 64'(o_store_ready), 1);
        if (with_inv) chk("inv_ack_next_idle", 64'(o_inv_ack), 1);
        @(posedge clk); #1;
        i_store_req = 1'b0; i_inv_req = 1'b0;
    endtask

    initial begin
        int op;
        #2;
        do_reset();
        // Gap-free refill at set 5, tag 0xABCDE, offset 6.
        do_refill(7'd5, 20'hABCDE, 3'd6, 0, 1'b0, 1'b0, '0, 1'b0, -1);
        // Refill with gaps, stores, a queued invalidate and a stalled same-set store.
        do_refill(7'd5, 20'h12345, 3'd2, 40, 1'b1, 1'b1, 7'd9, 1'b1, -1);
        do_store(10'h102);
        do_inv(7'd127);
        // Reset mid-refill after four beats.
        do_refill(7'd33, 20'h0F0F0, 3'd1, 0, 1'b0, 1'b0, '0, 1'b0, 4);
        for (int k = 0; k < 25; k++) begin
            op = $urandom_range(3);
            if (op <= 1)
                do_refill(IW'($urandom), TW'($urandom), OW'($urandom), $urandom_range(60),
                          1'($urandom), 1'($urandom), IW'($urandom), 1'($urandom), -1);
            else if (op == 2)
                do_inv(IW'($urandom));
            else
                do_store(AW'($urandom));
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("tag_queue_empty", 64'(tq.size()), 0);
        chk("data_queue_empty", 64'(dq.size()), 0);
        chk("refill_done_count", 64'(got_done), 64'(exp_done));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
